// File: rtl/txn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : txn_pkg
//  Description : Shared encodings for the transaction sequencing controller:
//                state codes (also shown on the HEX display), datapath
//                process codes and reject-reason codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package txn_pkg;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_CLEAR        = 4'd1,
      ST_LOAD_MEM     = 4'd2,
      ST_GET_PLAYER   = 4'd3,
      ST_GET_AMOUNT   = 4'd4,
      ST_CHECK_AMOUNT = 4'd5,
      ST_GET_KEY      = 4'd6,
      ST_CHECK_KEY    = 4'd7,
      ST_COMMIT       = 4'd8,
      ST_DONE         = 4'd9,
      ST_REJECT       = 4'd10
   } state_t;

   localparam logic [2:0] PROC_IDLE   = 3'b000;
   localparam logic [2:0] PROC_AMOUNT = 3'b001;
   localparam logic [2:0] PROC_KEY    = 3'b010;
   localparam logic [2:0] PROC_COMMIT = 3'b011;

   localparam logic [1:0] RSN_NONE    = 2'b00;
   localparam logic [1:0] RSN_FUNDS   = 2'b01;
   localparam logic [1:0] RSN_TIMEOUT = 2'b10;
   localparam logic [1:0] RSN_CANCEL  = 2'b11;

   // A transaction is in flight everywhere except the rest states.
   function automatic logic is_busy(input state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_REJECT));
   endfunction

   function automatic logic [2:0] proc_code(input state_t s);
      case (s)
         ST_CHECK_AMOUNT: return PROC_AMOUNT;
         ST_CHECK_KEY:    return PROC_KEY;
         ST_COMMIT:       return PROC_COMMIT;
         default:         return PROC_IDLE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_timer
//  Description : Wait counter with synchronous clear and count enable.
//                'expired' is high while the count equals 'limit'.
//  Ports       : clock, reset (async, active-high), clear, enable,
//                limit[TIMER_W-1:0], expired
//  Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
   parameter int TIMER_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == limit);

endmodule
`default_nettype wire

// File: rtl/transaction_control.sv
`default_nettype none
// ============================================================================
//  Module      : transaction_control
//  Description : Sequencing controller for the ledger transaction datapath.
//                Walks one transaction through clear, record load, player /
//                amount / key entry, timed amount and key checks and commit.
//  Ports       : clock, reset (async, active-high)
//                in : start, enter, cancel, done_step
//                out: dp_resetn, load_register, load_player, load_amount,
//                     load_key, process[2:0], write_en, busy, accepted,
//                     rejected, reason[1:0], state_out[3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module transaction_control
   import txn_pkg::*;
#(
   parameter int AMOUNT_WAIT = 4,
   parameter int KEY_TIMEOUT = 64,
   parameter int TIMER_W     = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       enter,
   input  logic       cancel,
   input  logic       done_step,
   output logic       dp_resetn,
   output logic       load_register,
   output logic       load_player,
   output logic       load_amount,
   output logic       load_key,
   output logic [2:0] process,
   output logic       write_en,
   output logic       busy,
   output logic       accepted,
   output logic       rejected,
   output logic [1:0] reason,
   output logic [3:0] state_out
);

   localparam logic [TIMER_W-1:0] C_AMOUNT_LIMIT = TIMER_W'(AMOUNT_WAIT - 1);
   localparam logic [TIMER_W-1:0] C_KEY_LIMIT    = TIMER_W'(KEY_TIMEOUT - 1);
   // COMMIT lasts two cycles: counts 0 and 1.
   localparam logic [TIMER_W-1:0] C_COMMIT_LIMIT = TIMER_W'(1);

   state_t             state_q,     state_d;
   logic [1:0]         reason_q,    reason_d;
   logic               dp_resetn_q, dp_resetn_d;
   logic               load_reg_q,  load_reg_d;
   logic [2:0]         process_q,   process_d;
   logic               write_en_q,  write_en_d;
   logic               busy_q,      busy_d;
   logic               accepted_q,  accepted_d;
   logic               rejected_q,  rejected_d;

   logic [TIMER_W-1:0] w_limit;
   logic               w_timer_en;
   logic               w_timer_clr;
   logic               w_expired;

   // ------------------------------------------------------------------
   // Wait timer: one instance, limit selected by the current state.
   // ------------------------------------------------------------------
   always_comb begin
      w_limit    = C_COMMIT_LIMIT;
      w_timer_en = 1'b0;
      case (state_q)
         ST_CHECK_AMOUNT: begin w_limit = C_AMOUNT_LIMIT; w_timer_en = 1'b1; end
         ST_CHECK_KEY:    begin w_limit = C_KEY_LIMIT;    w_timer_en = 1'b1; end
         ST_COMMIT:       begin w_limit = C_COMMIT_LIMIT; w_timer_en = 1'b1; end
         default:         ;
      endcase
   end

   // Every state entry restarts the count from zero.
   assign w_timer_clr = (state_d != state_q);

   step_timer #(
      .TIMER_W (TIMER_W)
   ) u_step_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (w_timer_clr),
      .enable  (w_timer_en),
      .limit   (w_limit),
      .expired (w_expired)
   );

   // ------------------------------------------------------------------
   // Next-state and registered-output computation.
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CLEAR;
         end
         ST_CLEAR:    state_d = ST_LOAD_MEM;
         ST_LOAD_MEM: state_d = ST_GET_PLAYER;
         ST_GET_PLAYER: begin
            if (cancel) begin
               state_d  = ST_REJECT;
               reason_d = RSN_CANCEL;
            end else if (enter) begin
               state_d = ST_GET_AMOUNT;
            end
         end
         ST_GET_AMOUNT: begin
            if (cancel) begin
               state_d  = ST_REJECT;
               reason_d = RSN_CANCEL;
            end else if (enter) begin
               state_d = ST_CHECK_AMOUNT;
            end
         end
         ST_CHECK_AMOUNT: begin
            // A pass on the final cycle still counts as a pass.
            if (done_step) begin
               state_d = ST_GET_KEY;
            end else if (w_expired) begin
               state_d  = ST_REJECT;
               reason_d = RSN_FUNDS;
            end
         end
         ST_GET_KEY: begin
            if (cancel) begin
               state_d  = ST_REJECT;
               reason_d = RSN_CANCEL;
            end else if (enter) begin
               state_d = ST_CHECK_KEY;
            end
         end
         ST_CHECK_KEY: begin
            if (done_step) begin
               state_d = ST_COMMIT;
            end else if (w_expired) begin
               state_d  = ST_REJECT;
               reason_d = RSN_TIMEOUT;
            end
         end
         ST_COMMIT: begin
            if (w_expired) state_d = ST_DONE;
         end
         ST_DONE, ST_REJECT: begin
            if (start) begin
               state_d  = ST_CLEAR;
               reason_d = RSN_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs follow the state being entered so they line up with it.
      dp_resetn_d = (state_d != ST_CLEAR);
      load_reg_d  = (state_d == ST_LOAD_MEM);
      process_d   = proc_code(state_d);
      busy_d      = is_busy(state_d);
      accepted_d  = (state_d == ST_DONE);
      rejected_d  = (state_d == ST_REJECT);
      // First COMMIT cycle arms the strobe for the second one.
      write_en_d  = (state_q == ST_COMMIT) && !w_expired;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         reason_q    <= RSN_NONE;
         dp_resetn_q <= 1'b0;
         load_reg_q  <= 1'b0;
         process_q   <= PROC_IDLE;
         write_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         accepted_q  <= 1'b0;
         rejected_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         reason_q    <= reason_d;
         dp_resetn_q <= dp_resetn_d;
         load_reg_q  <= load_reg_d;
         process_q   <= process_d;
         write_en_q  <= write_en_d;
         busy_q      <= busy_d;
         accepted_q  <= accepted_d;
         rejected_q  <= rejected_d;
      end
   end

   // Load strobes fire in the same cycle as the confirming 'enter' so the
   // datapath captures the entry on the edge that advances the state.
   // 'cancel' takes priority and suppresses the load.
   assign load_player = (state_q == ST_GET_PLAYER) && enter && !cancel;
   assign load_amount = (state_q == ST_GET_AMOUNT) && enter && !cancel;
   assign load_key    = (state_q == ST_GET_KEY)    && enter && !cancel;

   assign dp_resetn     = dp_resetn_q;
   assign load_register = load_reg_q;
   assign process       = process_q;
   assign write_en      = write_en_q;
   assign busy          = busy_q;
   assign accepted      = accepted_q;
   assign rejected      = rejected_q;
   assign reason        = reason_q;
   assign state_out     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_transaction_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transaction_control
//  Description : Directed self-checking bench for transaction_control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transaction_control;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       enter = 1'b0;
   logic       cancel = 1'b0;
   logic       done_step = 1'b0;
   logic       dp_resetn;
   logic       load_register;
   logic       load_player;
   logic       load_amount;
   logic       load_key;
   logic [2:0] process;
   logic       write_en;
   logic       busy;
   logic       accepted;
   logic       rejected;
   logic [1:0] reason;
   logic [3:0] state_out;

   int n_cmp = 0;
   int n_bad = 0;
   int n_wr  = 0;
   int n_lk  = 0;

   transaction_control #(
      .AMOUNT_WAIT (4),
      .KEY_TIMEOUT (64),
      .TIMER_W     (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .enter         (enter),
      .cancel        (cancel),
      .done_step     (done_step),
      .dp_resetn     (dp_resetn),
      .load_register (load_register),
      .load_player   (load_player),
      .load_amount   (load_amount),
      .load_key      (load_key),
      .process       (process),
      .write_en      (write_en),
      .busy          (busy),
      .accepted      (accepted),
      .rejected      (rejected),
      .reason        (reason),
      .state_out     (state_out)
   );

   always #5 clock = ~clock;

   // Running strobe counts, sampled at the active edge.
   always @(posedge clock) begin
      if (write_en) n_wr++;
      if (load_key) n_lk++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulse enter for one cycle; returns {load_player, load_amount, load_key}.
   task automatic do_enter(output logic [2:0] strobes);
      enter = 1'b1;
      #1;
      strobes = {load_player, load_amount, load_key};
      tick();
      enter = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic to_get_amount();
      logic [2:0] s;
      pulse_start();
      tick();
      tick();
      do_enter(s);
   endtask

   task automatic to_check_amount();
      logic [2:0] s;
      to_get_amount();
      do_enter(s);
   endtask

   // Count cycles spent in state 'st' (bounded).
   task automatic wait_leave(input logic [3:0] st, input int bound, output int cycles);
      cycles = 0;
      while (state_out == st && cycles < bound) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      logic [2:0] s;
      int cyc;
      int wr0;
      int lk0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_state", state_out, 0);
      check("rst_dp_resetn", dp_resetn, 0);
      check("rst_busy", busy, 0);
      check("rst_process", process, 0);
      check("rst_reason", reason, 0);
      check("rst_write_en", write_en, 0);
      reset = 1'b0;
      tick();
      check("post_rst_dp_resetn", dp_resetn, 1);
      check("post_rst_state", state_out, 0);

      // ---------------- happy path + protocol noise ----------------
      wr0 = n_wr;
      pulse_start();
      check("hp_clear_state", state_out, 1);
      check("hp_clear_dp_resetn", dp_resetn, 0);
      check("hp_clear_busy", busy, 1);
      tick();
      check("hp_loadmem_state", state_out, 2);
      check("hp_load_register", load_register, 1);
      tick();
      check("hp_getplayer_state", state_out, 3);
      check("hp_load_register_off", load_register, 0);
      do_enter(s);
      check("hp_load_player", s, 3'b100);
      check("hp_getamount_state", state_out, 4);
      do_enter(s);
      check("hp_load_amount", s, 3'b010);
      check("hp_checkamount_state", state_out, 5);
      check("hp_process_amount", process, 1);
      tick();
      enter = 1'b1;               // noise: enter during CHECK_AMOUNT
      #1;
      check("noise_enter_no_strobe", {load_player, load_amount, load_key}, 0);
      tick();
      enter = 1'b0;
      check("noise_enter_state", state_out, 5);
      done_step = 1'b1;           // third cycle in CHECK_AMOUNT
      tick();
      done_step = 1'b0;
      check("hp_getkey_state", state_out, 6);
      do_enter(s);
      check("hp_load_key", s, 3'b001);
      check("hp_checkkey_state", state_out, 7);
      check("hp_process_key", process, 2);
      for (int i = 0; i < 9; i++) begin
         start = (i == 3);         // noise: start during CHECK_KEY
         tick();
      end
      start = 1'b0;
      check("noise_start_state", state_out, 7);
      done_step = 1'b1;           // tenth cycle in CHECK_KEY
      tick();
      done_step = 1'b0;
      check("hp_commit_state", state_out, 8);
      check("hp_process_commit", process, 3);
      check("hp_commit1_write_en", write_en, 0);
      tick();
      check("hp_commit2_write_en", write_en, 1);
      tick();
      check("hp_done_state", state_out, 9);
      check("hp_accepted", accepted, 1);
      check("hp_reason", reason, 0);
      check("hp_busy_done", busy, 0);
      check("hp_write_en_off", write_en, 0);
      check("hp_write_en_count", n_wr - wr0, 1);

      // ---------------- insufficient funds ----------------
      wr0 = n_wr;
      lk0 = n_lk;
      to_check_amount();
      check("funds_accepted_cleared", accepted, 0);
      wait_leave(4'd5, 20, cyc);
      check("funds_cycles", cyc, 4);
      check("funds_state", state_out, 10);
      check("funds_reason", reason, 1);
      check("funds_rejected", rejected, 1);
      check("funds_no_load_key", n_lk - lk0, 0);
      check("funds_no_write_en", n_wr - wr0, 0);

      // ---------------- key timeout ----------------
      to_check_amount();
      check("kto_reason_cleared", reason, 0);
      done_step = 1'b1;
      tick();
      done_step = 1'b0;
      do_enter(s);
      wait_leave(4'd7, 200, cyc);
      check("kto_cycles", cyc, 64);
      check("kto_state", state_out, 10);
      check("kto_reason", reason, 2);

      // ---------------- pass on final key cycle ----------------
      wr0 = n_wr;
      to_check_amount();
      done_step = 1'b1;
      tick();
      done_step = 1'b0;
      do_enter(s);
      repeat (63) tick();
      check("klast_still_checking", state_out, 7);
      done_step = 1'b1;
      tick();
      done_step = 1'b0;
      check("klast_commit", state_out, 8);
      tick();
      tick();
      check("klast_done", state_out, 9);
      check("klast_write_en_count", n_wr - wr0, 1);

      // ---------------- cancel + enter in GET_AMOUNT ----------------
      to_get_amount();
      enter  = 1'b1;
      cancel = 1'b1;
      #1;
      check("cancel_no_load_amount", load_amount, 0);
      tick();
      enter  = 1'b0;
      cancel = 1'b0;
      check("cancel_state", state_out, 10);
      check("cancel_reason", reason, 3);
      pulse_start();
      check("restart_state", state_out, 1);
      check("restart_dp_resetn", dp_resetn, 0);
      check("restart_reason", reason, 0);
      tick();
      check("restart_dp_resetn_back", dp_resetn, 1);

      // ---------------- reset during first COMMIT cycle ----------------
      tick();                     // GET_PLAYER
      do_enter(s);
      do_enter(s);
      done_step = 1'b1;
      tick();
      done_step = 1'b0;
      do_enter(s);
      done_step = 1'b1;
      tick();
      done_step = 1'b0;
      check("rc_commit_state", state_out, 8);
      wr0 = n_wr;
      reset = 1'b1;
      #1;
      check("rc_state_idle", state_out, 0);
      check("rc_dp_resetn", dp_resetn, 0);
      check("rc_write_en", write_en, 0);
      check("rc_process", process, 0);
      check("rc_busy", busy, 0);
      tick();
      tick();
      check("rc_dp_resetn_held", dp_resetn, 0);
      reset = 1'b0;
      tick();
      check("rc_dp_resetn_release", dp_resetn, 1);
      check("rc_state_after", state_out, 0);
      check("rc_no_write_en", n_wr - wr0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
